// File: rtl/gcn_pkg.sv
// Shared GCN definitions: default widths and the combination-stage state type.
// Imported by the combination block and by the downstream argmax stage.
package gcn_pkg;

    localparam int unsigned DEF_FEATURE_ROWS   = 6;
    localparam int unsigned DEF_WEIGHT_COLS    = 3;
    localparam int unsigned DEF_DOT_PROD_WIDTH = 16;
    localparam int unsigned DEF_NUM_EDGES      = 6;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ACC_SRC,
        ACC_DST,
        DONE
    } comb_state_t;

endpackage

// File: rtl/combination_block_if.sv
// Fetch bus between the combination block and the FM_WM / COO edge memories.
// Both memories answer combinationally for the address currently presented.
interface combination_block_if #(
    parameter int unsigned FEATURE_WIDTH   = 3,
    parameter int unsigned EDGE_ADDR_WIDTH = 3,
    parameter int unsigned WEIGHT_COLS     = 3,
    parameter int unsigned DOT_PROD_WIDTH  = 16
);
    logic [FEATURE_WIDTH-1:0]                      fm_wm_read_row;
    logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]    fm_wm_row_in;
    logic [EDGE_ADDR_WIDTH-1:0]                    coo_address;
    logic [1:0][FEATURE_WIDTH-1:0]                 coo_in;

    modport master (
        output fm_wm_read_row,
        output coo_address,
        input  fm_wm_row_in,
        input  coo_in
    );

    modport slave (
        input  fm_wm_read_row,
        input  coo_address,
        output fm_wm_row_in,
        output coo_in
    );
endinterface

// File: rtl/vector_adder.sv
// Element-wise unsigned adder over one matrix row; each lane wraps at its width.
module vector_adder #(
    parameter int unsigned COLS  = 3,
    parameter int unsigned WIDTH = 16
) (
    input  logic [COLS-1:0][WIDTH-1:0] a,
    input  logic [COLS-1:0][WIDTH-1:0] b,
    output logic [COLS-1:0][WIDTH-1:0] sum
);
    always_comb begin
        sum = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            sum[c] = a[c] + b[c];
        end
    end
endmodule

// File: rtl/combination_block.sv
// Computes ADJ_FM_WM = (A + I) x FM_WM from a COO edge list into a flop array,
// then serves rows to the argmax stage through a combinational read port.
module combination_block
    import gcn_pkg::*;
#(
    parameter int unsigned FEATURE_ROWS    = DEF_FEATURE_ROWS,
    parameter int unsigned WEIGHT_COLS     = DEF_WEIGHT_COLS,
    parameter int unsigned DOT_PROD_WIDTH  = DEF_DOT_PROD_WIDTH,
    parameter int unsigned NUM_EDGES       = DEF_NUM_EDGES,
    parameter int unsigned FEATURE_WIDTH   = $clog2(FEATURE_ROWS),
    parameter int unsigned EDGE_ADDR_WIDTH = $clog2(NUM_EDGES)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   done_trans,
    combination_block_if.master                    bus,
    input  logic [FEATURE_WIDTH-1:0]               read_row,
    output logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] adj_fm_wm_row,
    output logic                                   done_comb
);
    typedef logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row_t;

    localparam logic [FEATURE_WIDTH:0]       ROWS_L    = (FEATURE_WIDTH+1)'(FEATURE_ROWS);
    localparam logic [FEATURE_WIDTH-1:0]     LAST_ROW  = FEATURE_WIDTH'(FEATURE_ROWS-1);
    localparam logic [EDGE_ADDR_WIDTH-1:0]   LAST_EDGE = EDGE_ADDR_WIDTH'(NUM_EDGES-1);

    row_t                       mem [FEATURE_ROWS];
    comb_state_t                state, next_state;
    logic [FEATURE_WIDTH-1:0]   row_cnt;
    logic [EDGE_ADDR_WIDTH-1:0] edge_cnt;
    logic [FEATURE_WIDTH-1:0]   src, dst, wr_addr;
    logic                       edge_ok, self_edge, last_edge, wr_en, edge_step, addr_ok;
    row_t                       acc_base, acc_sum, wr_data;

    assign src       = bus.coo_in[0];
    assign dst       = bus.coo_in[1];
    assign edge_ok   = ({1'b0, src} < ROWS_L) && ({1'b0, dst} < ROWS_L);
    assign self_edge = (src == dst);
    assign last_edge = (edge_cnt == LAST_EDGE);
    assign addr_ok   = ({1'b0, wr_addr} < ROWS_L);
    assign acc_base  = addr_ok ? mem[wr_addr] : '0;

    vector_adder #(
        .COLS  (WEIGHT_COLS),
        .WIDTH (DOT_PROD_WIDTH)
    ) u_adder (
        .a   (acc_base),
        .b   (bus.fm_wm_row_in),
        .sum (acc_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state         = state;
        bus.fm_wm_read_row = '0;
        bus.coo_address    = '0;
        wr_en              = 1'b0;
        wr_addr            = row_cnt;
        wr_data            = acc_sum;
        edge_step          = 1'b0;
        case (state)
            IDLE: if (done_trans) next_state = INIT;
            INIT: begin
                bus.fm_wm_read_row = row_cnt;
                wr_en              = 1'b1;
                wr_data            = bus.fm_wm_row_in;
                if (row_cnt == LAST_ROW) next_state = ACC_SRC;
            end
            // A self-edge finishes its edge here so it is counted only once.
            ACC_SRC: begin
                bus.coo_address    = edge_cnt;
                bus.fm_wm_read_row = dst;
                wr_en              = edge_ok;
                wr_addr            = src;
                if (!self_edge)     next_state = ACC_DST;
                else if (last_edge) next_state = DONE;
                else                edge_step  = 1'b1;
            end
            ACC_DST: begin
                bus.coo_address    = edge_cnt;
                bus.fm_wm_read_row = src;
                wr_en              = edge_ok;
                wr_addr            = dst;
                if (last_edge) next_state = DONE;
                else begin
                    next_state = ACC_SRC;
                    edge_step  = 1'b1;
                end
            end
            DONE:    ;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt   <= '0;
            edge_cnt  <= '0;
            done_comb <= 1'b0;
            for (int unsigned r = 0; r < FEATURE_ROWS; r++) mem[r] <= '0;
        end else begin
            done_comb <= (state == DONE);
            if (state == IDLE) begin
                row_cnt  <= '0;
                edge_cnt <= '0;
            end
            if (state == INIT) row_cnt <= row_cnt + 1'b1;
            if (edge_step)     edge_cnt <= edge_cnt + 1'b1;
            if (wr_en && addr_ok) mem[wr_addr] <= wr_data;
        end
    end

    assign adj_fm_wm_row = ({1'b0, read_row} < ROWS_L) ? mem[read_row] : '0;

endmodule

// File: tb/tb_combination_block.sv
// Self-checking bench for combination_block: directed cases plus random graphs
// compared against a plain-arithmetic (A + I) x FM_WM model.
module tb_combination_block;

    localparam int ROWS = 6;
    localparam int COLS = 3;
    localparam int W    = 16;
    localparam int NE   = 6;
    localparam int FW   = 3;
    localparam int EW   = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic done_trans = 1'b0;
    logic [FW-1:0] read_row = '0;
    logic [COLS-1:0][W-1:0] adj_fm_wm_row;
    logic done_comb;

    int n_cmp = 0;
    int n_mis = 0;

    logic [W-1:0] fm   [8][COLS];
    logic [FW-1:0] es  [8];
    logic [FW-1:0] ed  [8];
    logic [W-1:0] gold [ROWS][COLS];
    int exp_lat;

    combination_block_if #(
        .FEATURE_WIDTH   (FW),
        .EDGE_ADDR_WIDTH (EW),
        .WEIGHT_COLS     (COLS),
        .DOT_PROD_WIDTH  (W)
    ) bus ();

    combination_block #(
        .FEATURE_ROWS   (ROWS),
        .WEIGHT_COLS    (COLS),
        .DOT_PROD_WIDTH (W),
        .NUM_EDGES      (NE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .done_trans    (done_trans),
        .bus           (bus),
        .read_row      (read_row),
        .adj_fm_wm_row (adj_fm_wm_row),
        .done_comb     (done_comb)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int c = 0; c < COLS; c++) bus.fm_wm_row_in[c] = fm[bus.fm_wm_read_row][c];
        bus.coo_in[0] = es[bus.coo_address];
        bus.coo_in[1] = ed[bus.coo_address];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void build_model();
        int selfs = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) gold[r][c] = fm[r][c];
        for (int e = 0; e < NE; e++) begin
            int s = int'(es[e]);
            int d = int'(ed[e]);
            if (s == d) selfs++;
            if (s < ROWS && d < ROWS) begin
                for (int c = 0; c < COLS; c++) gold[s][c] = gold[s][c] + fm[d][c];
                if (s != d)
                    for (int c = 0; c < COLS; c++) gold[d][c] = gold[d][c] + fm[s][c];
            end
        end
        exp_lat = 1 + ROWS + 2 * NE - selfs;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        done_trans = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic read_check(input int r, input logic [47:0] exp, input string tag);
        @(negedge clk);
        read_row = FW'(r);
        #1;
        check_eq($sformatf("%s_row%0d", tag, r), 64'(adj_fm_wm_row), 64'(exp));
    endtask

    task automatic check_rows(input string tag);
        logic [47:0] x;
        for (int r = 0; r < 8; r++) begin
            x = '0;
            if (r < ROWS)
                for (int c = 0; c < COLS; c++) x[c*W +: W] = gold[r][c];
            read_check(r, x, tag);
        end
    endtask

    task automatic check_zero_rows(input string tag);
        for (int r = 0; r < 8; r++) read_check(r, 48'h0, tag);
    endtask

    // mode 0: drop done_trans after sampling, 1: hold high, 2: toggle every cycle
    task automatic run_check(input int mode, input string tag);
        int n = 0;
        bit seen = 0;
        build_model();
        @(negedge clk);
        check_eq({tag, "_idle_addr"}, 64'({bus.fm_wm_read_row, bus.coo_address}), 64'h0);
        done_trans = 1'b1;
        @(posedge clk);
        while (!seen && n < 200) begin
            @(negedge clk);
            if (mode == 0) done_trans = 1'b0;
            else if (mode == 2) done_trans = ~done_trans;
            @(posedge clk);
            n++;
            #1;
            if (done_comb) seen = 1;
        end
        check_eq({tag, "_latency"}, 64'(n), 64'(exp_lat));
        if (mode == 2) done_trans = 1'b0;
        @(negedge clk);
        check_eq({tag, "_done_addr"}, 64'({bus.fm_wm_read_row, bus.coo_address}), 64'h0);
        check_rows(tag);
    endtask

    task automatic load_golden_graph();
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < COLS; c++) fm[k][c] = W'(k + 1);
        for (int e = 0; e < 8; e++) begin
            es[e] = FW'(e);
            ed[e] = FW'(e + 1);
        end
        es[5] = 3'd5;
        ed[5] = 3'd5;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            es[k] = '0;
            ed[k] = '0;
            for (int c = 0; c < COLS; c++) fm[k][c] = '0;
        end

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("reset_done", 64'(done_comb), 64'h0);
        check_eq("reset_addr", 64'({bus.fm_wm_read_row, bus.coo_address}), 64'h0);
        check_zero_rows("reset");

        // Golden graph; done_trans held high afterwards must not start a second run
        load_golden_graph();
        run_check(1, "golden");
        read_check(0, 48'h0003_0003_0003, "golden_const");
        read_check(1, 48'h0006_0006_0006, "golden_const");
        read_check(3, 48'h000c_000c_000c, "golden_const");
        read_check(5, 48'h0011_0011_0011, "golden_const");
        check_eq("golden_latency_const", 64'(exp_lat), 64'd18);
        repeat (10) @(negedge clk);
        check_eq("hold_done", 64'(done_comb), 64'h1);
        check_eq("hold_addr", 64'({bus.fm_wm_read_row, bus.coo_address}), 64'h0);
        check_rows("hold");

        // Lane wrap-around
        do_reset();
        fm[0][0] = 16'hffff; fm[0][1] = 16'h0001; fm[0][2] = 16'h0000;
        fm[1][0] = 16'h0002; fm[1][1] = 16'hffff; fm[1][2] = 16'h0000;
        es[0] = 3'd0; ed[0] = 3'd1;
        for (int e = 1; e < NE; e++) begin
            es[e] = 3'd2;
            ed[e] = 3'd2;
        end
        run_check(0, "wrap");
        read_check(0, 48'h0000_0000_0001, "wrap_const");

        // Reset five cycles into the accumulate phase aborts the run
        do_reset();
        load_golden_graph();
        @(negedge clk);
        done_trans = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_trans = 1'b0;
        repeat (ROWS + 4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("abort_done", 64'(done_comb), 64'h0);
        check_zero_rows("abort");
        repeat (30) @(negedge clk);
        check_eq("abort_no_restart", 64'(done_comb), 64'h0);
        run_check(2, "rerun_toggle");

        // Out-of-range source node
        do_reset();
        load_golden_graph();
        es[2] = 3'd7;
        ed[2] = 3'd0;
        run_check(0, "oor");

        for (int t = 0; t < 8; t++) begin
            do_reset();
            for (int k = 0; k < 8; k++)
                for (int c = 0; c < COLS; c++) fm[k][c] = W'($urandom);
            for (int e = 0; e < 8; e++) begin
                es[e] = FW'($urandom_range(0, 7));
                ed[e] = ($urandom_range(0, 3) == 0) ? es[e] : FW'($urandom_range(0, 7));
            end
            run_check(int'($urandom_range(0, 2)), $sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
